// File: rtl/muldiv_unit_if.sv
// Bus between the execute-stage controller and the multiply/divide unit:
// launch handshake, operands, MTHI/MTLO writes and the HI/LO read ports.
interface muldiv_unit_if #(
    parameter int N = 32
) ();
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         hi_we;
    logic         lo_we;
    logic [N-1:0] wdata;
    logic         busy;
    logic         done;
    logic [N-1:0] hi;
    logic [N-1:0] lo;

    // Controller side: launches operations, writes HI/LO, reads results.
    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    // Unit side.
    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use radix-2 shift-add, DIV/DIVU use restoring division.
// Both work on magnitudes for N cycles, then a single FIX cycle applies
// sign correction and commits HI/LO.
module muldiv_unit #(
    parameter int N = 32
) (
    input logic           clk,
    input logic           reset,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [CW-1:0]  cnt;

    // Latched operation context.
    logic [1:0]     op_q;       // op[1]: divide, op[0]: unsigned
    logic           res_neg;    // product / quotient must be negated
    logic           dvd_neg;    // remainder must be negated (dividend sign)
    logic           div_zero;

    // Shared datapath: multiply keeps {rem[N-1:0], quo} as the 2N-bit
    // accumulator with the multiplier shifting out of quo; divide keeps
    // the partial remainder in rem and grows the quotient in quo.
    logic [N-1:0]   opnd;       // multiplicand or divisor magnitude
    logic [N-1:0]   quo;
    logic [N:0]     rem;

    logic [N-1:0]   hi_q;
    logic [N-1:0]   lo_q;
    logic           done_q;

    logic           accept;
    logic           last_iter;
    logic           a_neg;
    logic           b_neg;
    logic [N-1:0]   mag_a;
    logic [N-1:0]   mag_b;

    logic [N:0]     mul_sum;
    logic [N:0]     shifted;
    logic [N:0]     trial;
    logic [N:0]     rem_nxt;
    logic [N-1:0]   quo_nxt;

    logic [2*N-1:0] prod;
    logic [2*N-1:0] prod_fix;
    logic [N-1:0]   quot_fix;
    logic [N-1:0]   rem_fix;
    logic [N-1:0]   fix_hi;
    logic [N-1:0]   fix_lo;

    assign accept    = (state == IDLE) && bus.start;
    assign last_iter = (cnt == CW'(N - 1));

    // Signs only matter for MULT/DIV (op[0] == 0).
    assign a_neg = ~bus.op[0] & bus.a[N-1];
    assign b_neg = ~bus.op[0] & bus.b[N-1];
    assign mag_a = a_neg ? -bus.a : bus.a;
    assign mag_b = b_neg ? -bus.b : bus.b;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: every clocked register in this design is written with
        // non-blocking assignments so all flops update from pre-edge values.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: IDLE -> RUN (N cycles) -> FIX -> IDLE.
    always_comb begin
        // NOTE: default assigned first so no path leaves next_state unassigned
        // (which would infer a latch).
        next_state = state;
        unique case (state)
            IDLE:    if (bus.start) next_state = RUN;
            RUN:     if (last_iter) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        mul_sum = rem + (quo[0] ? {1'b0, opnd} : '0);
        shifted = {rem[N-1:0], quo[N-1]};
        trial   = shifted - {1'b0, opnd};
        rem_nxt = rem;
        quo_nxt = quo;
        if (op_q[1]) begin
            if (!trial[N]) begin
                rem_nxt = trial;
                quo_nxt = {quo[N-2:0], 1'b1};
            end else begin
                rem_nxt = shifted;
                quo_nxt = {quo[N-2:0], 1'b0};
            end
        end else begin
            rem_nxt = {1'b0, mul_sum[N:1]};
            quo_nxt = {mul_sum[0], quo[N-1:1]};
        end
    end

    // Sign correction of the finished magnitudes. For divide by zero the
    // restoring loop leaves the dividend magnitude in rem, so the usual
    // remainder sign fix already reproduces the latched a for HI.
    always_comb begin
        prod     = {rem[N-1:0], quo};
        prod_fix = res_neg ? -prod : prod;
        quot_fix = res_neg ? -quo : quo;
        rem_fix  = dvd_neg ? -rem[N-1:0] : rem[N-1:0];
        if (op_q[1]) begin
            fix_hi = rem_fix;
            fix_lo = div_zero ? '1 : quot_fix;
        end else begin
            fix_hi = prod_fix[2*N-1:N];
            fix_lo = prod_fix[N-1:0];
        end
    end

    // Operand latch on accepted start, then iterate during RUN.
    always_ff @(posedge clk) begin
        // NOTE: only the counter is reset; the datapath registers are fully
        // reloaded on every accepted start and never reach hi/lo outside FIX.
        if (reset) begin
            cnt <= '0;
        end else if (accept) begin
            op_q     <= bus.op;
            opnd     <= bus.op[1] ? mag_b : mag_a;
            quo      <= bus.op[1] ? mag_a : mag_b;
            rem      <= '0;
            res_neg  <= a_neg ^ b_neg;
            dvd_neg  <= a_neg;
            div_zero <= (bus.b == '0);
            cnt      <= '0;
        end else if (state == RUN) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + 1'b1;
        end
    end

    // HI/LO commit at the end of FIX, MTHI/MTLO writes in idle, done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == FIX);
            if (state == FIX) begin
                hi_q <= fix_hi;
                lo_q <= fix_lo;
            end else if (state == IDLE && !bus.start) begin
                if (bus.hi_we) hi_q <= bus.wdata;
                if (bus.lo_we) lo_q <= bus.wdata;
            end
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (N = 32): directed vector table run
// back-to-back, hand-written corner sequences, and random operations
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;
    localparam int N = 32;

    logic clk;
    logic reset;

    muldiv_unit_if #(.N(N)) bus ();

    muldiv_unit #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    // Reference: {hi, lo} from 64-bit integer arithmetic.
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] ua;
        logic [63:0] ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            2'b00: return 64'(sa * sb);
            2'b01: return ua * ub;
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge; presents start for one rising edge, then
    // scrambles the operand inputs (they need not stay stable).
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        pre_hi    = bus.hi;
        pre_lo    = bus.lo;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.op    = 2'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    // Follows cycles t+1 .. t+N+2 at each negedge and checks latency and
    // result. poke_cycle > 0 drives start/hi_we/lo_we for one mid-run cycle.
    // Returns at the negedge of the done cycle.
    task automatic wait_result(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                               input int poke_cycle);
        int  busy_cnt;
        int  early_done;
        bit  changed;
        busy_cnt   = 0;
        early_done = 0;
        changed    = 1'b0;
        for (int k = 1; k <= N + 1; k++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) early_done++;
            if (bus.hi !== pre_hi || bus.lo !== pre_lo) changed = 1'b1;
            if (k == poke_cycle) begin
                bus.start = 1'b1;
                bus.hi_we = 1'b1;
                bus.lo_we = 1'b1;
                bus.wdata = 32'hDEAD_BEEF;
                bus.op    = 2'b11;
            end else begin
                bus.start = 1'b0;
                bus.hi_we = 1'b0;
                bus.lo_we = 1'b0;
            end
        end
        @(negedge clk);
        check({name, " busy_cycles"}, 64'(busy_cnt), 64'(N + 1));
        check({name, " early_done"}, 64'(early_done), 64'd0);
        check({name, " hilo_stable_in_run"}, {63'd0, changed}, 64'd0);
        check({name, " done"}, {62'd0, bus.done, bus.busy}, 64'b10);
        check({name, " result"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
    endtask

    vec_t        vecs[$];
    logic [63:0] exp;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          extra_done;

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;

        vecs.push_back('{"mult_neg3x5",    2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1});
        vecs.push_back('{"multu_max",      2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
        vecs.push_back('{"mult_m1xm1",     2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001});
        vecs.push_back('{"div_neg7by2",    2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD});
        vecs.push_back('{"divu_100by7",    2'b11, 32'd100,       32'd7,         32'd2,         32'd14});
        vecs.push_back('{"div_overflow",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
        vecs.push_back('{"divu_by_zero",   2'b11, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF});
        vecs.push_back('{"div_neg_by_zero",2'b10, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF});
        vecs.push_back('{"div_7byneg2",    2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD});
        vecs.push_back('{"multu_2p16sq",   2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000});
        vecs.push_back('{"mult_minsq",     2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {62'd0, bus.busy, bus.done}, 64'd0);
        check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed table, each op started in the previous op's done cycle.
        foreach (vecs[i]) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_result(vecs[i].name, vecs[i].exp_hi, vecs[i].exp_lo, 0);
        end
        @(negedge clk);
        check("done_one_cycle", {63'd0, bus.done}, 64'd0);

        // MTHI / MTLO in idle.
        pre_lo    = bus.lo;
        bus.hi_we = 1'b1;
        bus.wdata = 32'hA5A5_A5A5;
        @(posedge clk);
        #1 bus.hi_we = 1'b0;
        @(negedge clk);
        check("mthi", {bus.hi, bus.lo}, {32'hA5A5_A5A5, pre_lo});
        bus.lo_we = 1'b1;
        bus.wdata = 32'h5A5A_0F0F;
        @(posedge clk);
        #1 bus.lo_we = 1'b0;
        @(negedge clk);
        check("mtlo", {bus.hi, bus.lo}, {32'hA5A5_A5A5, 32'h5A5A_0F0F});
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0BAD_CAFE;
        @(posedge clk);
        #1 begin bus.hi_we = 1'b0; bus.lo_we = 1'b0; end
        @(negedge clk);
        check("mthi_mtlo_both", {bus.hi, bus.lo}, {32'h0BAD_CAFE, 32'h0BAD_CAFE});

        // start together with hi_we/lo_we: writes dropped, op runs.
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h1111_2222;
        start_op(2'b11, 32'd1000, 32'd33);
        wait_result("start_with_mt", 32'd10, 32'd30, 0);

        // Mid-operation start and MTHI/MTLO are ignored; no second done.
        exp = ref_model(2'b00, 32'hFFFF_1234, 32'h0000_7777);
        start_op(2'b00, 32'hFFFF_1234, 32'h0000_7777);
        wait_result("mid_op_poke", exp[63:32], exp[31:0], 5);
        extra_done = 0;
        for (int k = 0; k < N + 6; k++) begin
            @(negedge clk);
            if (bus.done) extra_done++;
        end
        check("no_second_done", 64'(extra_done), 64'd0);
        check("hilo_after_poke", {bus.hi, bus.lo}, exp);

        // Reset during a MULTU at t+10.
        start_op(2'b01, 32'hFFFF_FFFF, 32'h1234_5678);
        for (int k = 1; k <= 10; k++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid_busy", {63'd0, bus.busy}, 64'd0);
        check("reset_mid_hilo", {bus.hi, bus.lo}, 64'd0);
        reset = 1'b0;
        extra_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) extra_done++;
        end
        check("reset_no_done", 64'(extra_done), 64'd0);

        // Random operations against the reference model, back-to-back.
        for (int i = 0; i < 150; i++) begin
            rop = 2'($urandom);
            ra  = pick();
            rb  = pick();
            exp = ref_model(rop, ra, rb);
            start_op(rop, ra, rb);
            wait_result($sformatf("rand%0d_op%0d", i, rop), exp[63:32], exp[31:0], 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit in the execute stage, alongside the ALU. It consumes the same source operands the ALU sees and handles MULT, MULTU, DIV and DIVU, which the ALU does not implement. Results go into architectural HI/LO registers, which are also directly writable for MTHI/MTLO. The controller stalls the datapath on `busy` and resumes on `done`.

## Interface
- `N`, default 32: operand and HI/LO width; must be even and ≥ 4.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  launch operation; accepted only in IDLE.
- `op`  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `a`  in  N  rs operand (multiplicand / dividend); sampled on accepted `start`.
- `b`  in  N  rt operand (multiplier / divisor); sampled on accepted `start`.
- `hi_we`  in  1  MTHI write enable.
- `lo_we`  in  1  MTLO write enable.
- `wdata`  in  N  MTHI/MTLO data.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- `hi`  out  N  HI register (MFHI source).
- `lo`  out  N  LO register (MFLO source).

## Operation
- FSM states: IDLE → RUN (exactly N cycles) → FIX (1 cycle) → IDLE.
- On `start` in IDLE:
  - latch `op` and operand magnitudes (absolute value for signed ops, raw value for unsigned);
  - record the result sign, and for DIV the dividend sign;
  - clear the iteration counter.
- RUN, multiply: radix-2 shift-add on the unsigned magnitudes over a 2N-bit accumulator; one multiplier bit per cycle, LSB first.
- RUN, divide: restoring division on the magnitudes; one quotient bit per cycle, MSB first. The remainder register is N+1 bits wide to hold the trial subtract.
- FIX: apply sign correction, write HI/LO, move to IDLE.
  - MULT: 2N-bit product negated if the operand signs differ. HI = upper N bits, LO = lower N bits.
  - DIV: quotient truncates toward zero. The remainder takes the dividend's sign. LO = quotient, HI = remainder.
  - MULTU/DIVU: no correction.
- Divide by zero: completes with normal latency; LO = all ones, HI = `a` as latched, for both DIV and DIVU.
- Signed overflow (DIV of −2^(N−1) by −1): LO = −2^(N−1) (0x80000000 for N=32), HI = 0.
- MTHI/MTLO:
  - honoured only in IDLE; `hi_we` writes HI and `lo_we` writes LO, each from `wdata`, effective the next cycle;
  - if both are set, both registers get `wdata`;
  - ignored while `busy`.
- `start` while busy: ignored; the in-flight operation is unaffected.
- `start` with `hi_we`/`lo_we` in the same IDLE cycle: `start` is accepted and the writes are dropped.
- HI/LO change only at the end of FIX, on an MTHI/MTLO write, or on reset. Intermediate datapath state is never visible on `hi`/`lo`.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0.
- Reset mid-operation: in the next cycle the state is IDLE, `busy`=0 and HI/LO=0. No `done` is produced for the aborted operation.
- For `start` accepted in cycle t:
  - `busy`=1 in cycles t+1 … t+N+1;
  - `done`=1 and new HI/LO in cycle t+N+2, with `busy`=0 in that cycle.
  - Total latency: N+2 cycles (34 for N=32).
- `done` is registered and high for exactly one cycle. It is never asserted together with `busy`.
- A new `start` is accepted in the `done` cycle (back-to-back operation). MTHI/MTLO are also accepted in that cycle.
- Operands are not required to stay stable after the accepting cycle.
- `busy` and `done` depend only on state, never combinationally on inputs.

## Test plan
- MULT a=0xFFFFFFFD (−3), b=5 → at t+34: `done`=1, HI=0xFFFFFFFF, LO=0xFFFFFFF1. `busy` high for exactly 33 cycles beforehand.
- MULTU a=b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. Then immediately MULT with the same operands, started in the `done` cycle → HI=0, LO=1.
- Three divides:
  - DIV a=0xFFFFFFF9 (−7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU a=100, b=7 → LO=14, HI=2.
  - DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU a=0x12345678, b=0 → LO=0xFFFFFFFF, HI=0x12345678, normal latency.
- MTHI/MTLO and busy behaviour:
  - `hi_we` with `wdata`=0xA5A5A5A5 in IDLE → HI=0xA5A5A5A5 next cycle.
  - `hi_we`/`start` asserted in mid-operation cycles → HI/LO unchanged except by the in-flight result; the extra `start` produces no second `done`.
- Assert `reset` at t+10 of a MULTU → `busy`=0 and HI=LO=0 at t+11; no `done` pulse within the following 40 cycles.
